// File: rtl/fft_buffer_mem.sv
// Multi-bank FFT sample memory. It has an engine port bound to the current engine bank
// and a host port that addresses any bank, with starvation-protected arbitration
// and drain-then-swap bank rotation.
// Optional macro FFT_BUF_PARITY_EN adds one stored even-parity bit per word.
module fft_buffer_mem #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 1024,
    parameter int NUM_BUFS     = 2,
    parameter int STARVE_LIMIT = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  eng_req_valid_i,
    output logic                  eng_req_ready_o,
    input  logic                  eng_req_write_i,
    input  logic [AW-1:0]         eng_req_addr_i,
    input  logic [DATA_WIDTH-1:0] eng_req_wdata_i,
    output logic                  eng_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] eng_rsp_rdata_o,
    input  logic                  host_req_valid_i,
    output logic                  host_req_ready_o,
    input  logic                  host_req_write_i,
    input  logic [BW+AW-1:0]      host_req_addr_i,
    input  logic [DATA_WIDTH-1:0] host_req_wdata_i,
    output logic                  host_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] host_rsp_rdata_o,
    output logic                  host_rsp_err_o,
    input  logic                  swap_req_i,
    output logic                  swap_ack_o,
    output logic [BW-1:0]         eng_buf_o,
    input  logic                  parity_inject_i,
    output logic                  parity_err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_SWAP  = 2'd2;

    localparam int SW = $clog2(STARVE_LIMIT + 1);

`ifdef FFT_BUF_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    logic [1:0]    state;
    logic [SW-1:0] starve_cnt;
    logic [MW-1:0] mem [NUM_BUFS*DEPTH];

    logic [BW-1:0]    host_buf;
    logic [AW-1:0]    host_off;
    logic             host_oor;
    logic             conflict;
    logic             starve_hit;
    logic [BW+AW-1:0] eng_idx;
    logic [BW+AW-1:0] host_idx;
    logic             eng_acc;
    logic             host_acc;
    logic             host_mem_acc;
    logic [MW-1:0]    eng_wword;
    logic [MW-1:0]    host_wword;
    logic [MW-1:0]    eng_rword;
    logic [MW-1:0]    host_rword;

    assign host_buf = host_req_addr_i[AW +: BW];
    assign host_off = host_req_addr_i[AW-1:0];
    assign eng_idx  = {eng_buf_o, eng_req_addr_i};
    assign host_idx = {host_buf, host_off};

    // Indices that the bank field can encode but that do not exist are out of range.
    generate
        if ((2 ** BW) > NUM_BUFS) begin : g_oor
            assign host_oor = (host_buf >= BW'(NUM_BUFS));
        end else begin : g_no_oor
            assign host_oor = 1'b0;
        end
    endgenerate

    assign conflict   = eng_req_valid_i && host_req_valid_i && !host_oor &&
                        (host_buf == eng_buf_o) && (state == S_IDLE);
    assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));

    assign eng_req_ready_o  = (state == S_IDLE) && !(conflict && starve_hit);
    assign host_req_ready_o = !conflict || starve_hit;

    assign eng_acc      = eng_req_valid_i && eng_req_ready_o;
    assign host_acc     = host_req_valid_i && host_req_ready_o;
    assign host_mem_acc = host_acc && !host_oor;

    assign eng_rword  = mem[eng_idx];
    assign host_rword = mem[host_idx];

`ifdef FFT_BUF_PARITY_EN
    assign eng_wword  = {(^eng_req_wdata_i) ^ parity_inject_i, eng_req_wdata_i};
    assign host_wword = {(^host_req_wdata_i) ^ parity_inject_i, host_req_wdata_i};
`else
    logic unused_parity_inject;
    assign unused_parity_inject = parity_inject_i;
    assign eng_wword  = eng_req_wdata_i;
    assign host_wword = host_req_wdata_i;
`endif

    // Storage is never reset; arbitration guarantees the two write ports never hit the same word.
    always_ff @(posedge clk_i) begin
        if (eng_acc && eng_req_write_i) begin
            mem[eng_idx] <= eng_wword;
        end
        if (host_mem_acc && host_req_write_i) begin
            mem[host_idx] <= host_wword;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt <= '0;
        end else if (!host_req_valid_i || host_acc) begin
            starve_cnt <= '0;
        end else if (conflict) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            eng_rsp_valid_o  <= 1'b0;
            eng_rsp_rdata_o  <= '0;
            host_rsp_valid_o <= 1'b0;
            host_rsp_rdata_o <= '0;
            host_rsp_err_o   <= 1'b0;
        end else begin
            eng_rsp_valid_o  <= eng_acc && !eng_req_write_i;
            host_rsp_valid_o <= host_acc && !host_req_write_i;
            host_rsp_err_o   <= host_acc && !host_req_write_i && host_oor;
            if (eng_acc && !eng_req_write_i) begin
                eng_rsp_rdata_o <= eng_rword[DATA_WIDTH-1:0];
            end
            if (host_acc && !host_req_write_i) begin
                host_rsp_rdata_o <= host_oor ? '0 : host_rword[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef FFT_BUF_PARITY_EN
    // With the stored bit included, a clean word always reduces to even parity.
    logic eng_perr;
    logic host_perr;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            eng_perr  <= 1'b0;
            host_perr <= 1'b0;
        end else begin
            eng_perr  <= eng_acc && !eng_req_write_i && (^eng_rword);
            host_perr <= host_mem_acc && !host_req_write_i && (^host_rword);
        end
    end

    assign parity_err_o = eng_perr || host_perr;
`else
    assign parity_err_o = 1'b0;
`endif

    // Rotation: one drain cycle, one swap cycle, then the ack shows in the first idle cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= S_IDLE;
            eng_buf_o  <= '0;
            swap_ack_o <= 1'b0;
        end else begin
            swap_ack_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (swap_req_i) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state <= S_SWAP;
                end
                S_SWAP: begin
                    state      <= S_IDLE;
                    swap_ack_o <= 1'b1;
                    eng_buf_o  <= (eng_buf_o == BW'(NUM_BUFS - 1)) ? '0 : eng_buf_o + 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_buffer_mem.sv
// Directed self-checking bench for fft_buffer_mem: a vector table plus hand-written
// sequences for starvation, rotation, reset during a drain, parity and out-of-range host access.
module tb_fft_buffer_mem;

    localparam int DW = 32;

`ifdef FFT_BUF_PARITY_EN
    localparam logic PAR_EXP = 1'b1;
`else
    localparam logic PAR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic          ev, ew, hv, hw, swap_req, pinj;
    logic [3:0]    ea;
    logic [4:0]    ha;
    logic [DW-1:0] ed, hd;
    logic          e_ready, h_ready, e_rv, h_rv, h_err, ack, perr;
    logic [DW-1:0] e_rd, h_rd;
    logic [0:0]    ebuf;

    fft_buffer_mem #(.DATA_WIDTH(DW), .DEPTH(16), .NUM_BUFS(2), .STARVE_LIMIT(4)) u_dut (
        .clk_i(clk), .reset_i(rst),
        .eng_req_valid_i(ev), .eng_req_ready_o(e_ready), .eng_req_write_i(ew),
        .eng_req_addr_i(ea), .eng_req_wdata_i(ed),
        .eng_rsp_valid_o(e_rv), .eng_rsp_rdata_o(e_rd),
        .host_req_valid_i(hv), .host_req_ready_o(h_ready), .host_req_write_i(hw),
        .host_req_addr_i(ha), .host_req_wdata_i(hd),
        .host_rsp_valid_o(h_rv), .host_rsp_rdata_o(h_rd), .host_rsp_err_o(h_err),
        .swap_req_i(swap_req), .swap_ack_o(ack), .eng_buf_o(ebuf),
        .parity_inject_i(pinj), .parity_err_o(perr)
    );

    // Three-bank instance so the host can name an index that does not exist.
    logic          h3v, h3w;
    logic [5:0]    h3a;
    logic [DW-1:0] h3d;
    logic          h3_ready, h3_rv, h3_err;
    logic [DW-1:0] h3_rd;
    logic          e3_ready, e3_rv, ack3, perr3;
    logic [DW-1:0] e3_rd;
    logic [1:0]    ebuf3;
    logic          zero1 = 1'b0;
    logic [3:0]    zero4 = '0;
    logic [DW-1:0] zerod = '0;

    fft_buffer_mem #(.DATA_WIDTH(DW), .DEPTH(16), .NUM_BUFS(3), .STARVE_LIMIT(4)) u_dut3 (
        .clk_i(clk), .reset_i(rst),
        .eng_req_valid_i(zero1), .eng_req_ready_o(e3_ready), .eng_req_write_i(zero1),
        .eng_req_addr_i(zero4), .eng_req_wdata_i(zerod),
        .eng_rsp_valid_o(e3_rv), .eng_rsp_rdata_o(e3_rd),
        .host_req_valid_i(h3v), .host_req_ready_o(h3_ready), .host_req_write_i(h3w),
        .host_req_addr_i(h3a), .host_req_wdata_i(h3d),
        .host_rsp_valid_o(h3_rv), .host_rsp_rdata_o(h3_rd), .host_rsp_err_o(h3_err),
        .swap_req_i(zero1), .swap_ack_o(ack3), .eng_buf_o(ebuf3),
        .parity_inject_i(zero1), .parity_err_o(perr3)
    );

    typedef struct {
        logic          ev, ew;
        logic [3:0]    ea;
        logic [DW-1:0] ed;
        logic          hv, hw;
        logic [4:0]    ha;
        logic [DW-1:0] hd;
        logic          xer, xhr, xev;
        logic [DW-1:0] xed;
        logic          xhv;
        logic [DW-1:0] xhd;
    } vec_t;

    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ev = v.ev; ew = v.ew; ea = v.ea; ed = v.ed;
        hv = v.hv; hw = v.hw; ha = v.ha; hd = v.hd;
        #1;
        chk("vec eng_ready", 32'(e_ready), 32'(v.xer));
        chk("vec host_ready", 32'(h_ready), 32'(v.xhr));
    endtask

    task automatic checkOutput(input vec_t v);
        chk("vec eng_rsp_valid", 32'(e_rv), 32'(v.xev));
        if (v.xev) chk("vec eng_rdata", e_rd, v.xed);
        chk("vec host_rsp_valid", 32'(h_rv), 32'(v.xhv));
        if (v.xhv) chk("vec host_rdata", h_rd, v.xhd);
    endtask

    task automatic idleInputs();
        ev = 1'b0; ew = 1'b0; ea = '0; ed = '0;
        hv = 1'b0; hw = 1'b0; ha = '0; hd = '0;
        swap_req = 1'b0; pinj = 1'b0;
        h3v = 1'b0; h3w = 1'b0; h3a = '0; h3d = '0;
    endtask

    // Full rotation with no other traffic; the ack must land three cycles after the request.
    task automatic doSwap(input logic [0:0] exp_buf);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        chk("swap ack early", 32'(ack), 32'd0);
        @(negedge clk);
        chk("swap ack early2", 32'(ack), 32'd0);
        @(negedge clk);
        chk("swap ack", 32'(ack), 32'd1);
        chk("swap eng_buf", 32'(ebuf), 32'(exp_buf));
        @(negedge clk);
        chk("swap ack one-shot", 32'(ack), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 4'd5, 32'hA5A5_0001, 1'b0, 1'b0, 5'h00, 32'h0,
                    1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 4'd5, 32'h0, 1'b0, 1'b0, 5'h00, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 4'd5, 32'hCAFE_0005, 1'b1, 1'b1, 5'h15, 32'h0000_1234,
                    1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 4'd5, 32'h0, 1'b1, 1'b0, 5'h15, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'hCAFE_0005, 1'b1, 32'h0000_1234};
        vecs[4] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 5'h03, 32'h0000_0033,
                    1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 4'd3, 32'h0, 1'b0, 1'b0, 5'h00, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h0000_0033, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 4'd7, 32'h0000_0077, 1'b1, 1'b1, 5'h07, 32'hDEAD_0007,
                    1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 4'd7, 32'h0, 1'b0, 1'b0, 5'h00, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h0000_0077, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 5'h07, 32'h0,
                    1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0077};

        idleInputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset eng_rsp_valid", 32'(e_rv), 32'd0);
        chk("reset eng_rdata", e_rd, 32'd0);
        chk("reset host_rsp_valid", 32'(h_rv), 32'd0);
        chk("reset host_rdata", h_rd, 32'd0);
        chk("reset host_err", 32'(h_err), 32'd0);
        chk("reset swap_ack", 32'(ack), 32'd0);
        chk("reset eng_buf", 32'(ebuf), 32'd0);
        chk("reset parity_err", 32'(perr), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i]);
        end
        idleInputs();
        @(negedge clk);

        // Host keeps hitting the engine bank: four losses, a forced win, then losing again.
        for (int i = 0; i < 6; i++) begin
            ev = 1'b1; ew = 1'b1; ea = 4'(8 + i); ed = 32'(i);
            hv = 1'b1; hw = 1'b0; ha = 5'h03;
            #1;
            chk("starve eng_ready", 32'(e_ready), (i == 4) ? 32'd0 : 32'd1);
            chk("starve host_ready", 32'(h_ready), (i == 4) ? 32'd1 : 32'd0);
            @(negedge clk);
            chk("starve host_rsp_valid", 32'(h_rv), (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) chk("starve host_rdata", h_rd, 32'h0000_0033);
        end
        idleInputs();
        @(negedge clk);

        doSwap(1'b1);
        ev = 1'b1; ew = 1'b0; ea = 4'd5;
        @(negedge clk);
        ev = 1'b0;
        chk("bank1 eng_rsp_valid", 32'(e_rv), 32'd1);
        chk("bank1 eng_rdata", e_rd, 32'h0000_1234);

        // Rotation 1 -> 0 with a read in flight, a repeat request while draining, host traffic.
        ev = 1'b1; ew = 1'b0; ea = 4'd5; swap_req = 1'b1;
        #1 chk("swap c0 eng_ready", 32'(e_ready), 32'd1);
        @(negedge clk);
        hv = 1'b1; hw = 1'b0; ha = 5'h15;
        #1;
        chk("drain eng_ready", 32'(e_ready), 32'd0);
        chk("drain host_ready", 32'(h_ready), 32'd1);
        chk("drain eng_rsp_valid", 32'(e_rv), 32'd1);
        chk("drain eng_rdata", e_rd, 32'h0000_1234);
        @(negedge clk);
        swap_req = 1'b0; hv = 1'b0;
        #1;
        chk("swapst eng_ready", 32'(e_ready), 32'd0);
        chk("swapst ack", 32'(ack), 32'd0);
        chk("swapst host_rsp_valid", 32'(h_rv), 32'd1);
        chk("swapst host_rdata", h_rd, 32'h0000_1234);
        chk("swapst eng_rsp_valid", 32'(e_rv), 32'd0);
        @(negedge clk);
        #1;
        chk("ack cycle ack", 32'(ack), 32'd1);
        chk("ack cycle eng_buf", 32'(ebuf), 32'd0);
        chk("ack cycle eng_ready", 32'(e_ready), 32'd1);
        @(negedge clk);
        ev = 1'b0;
        chk("post swap ack", 32'(ack), 32'd0);
        chk("bank0 intact valid", 32'(e_rv), 32'd1);
        chk("bank0 intact rdata", e_rd, 32'hCAFE_0005);
        repeat (3) begin
            @(negedge clk);
            chk("ignored swap ack", 32'(ack), 32'd0);
        end

        // Reset lands in the drain cycle, together with a host read that must be discarded.
        doSwap(1'b1);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        rst = 1'b1;
        hv = 1'b1; hw = 1'b0; ha = 5'h15;
        @(negedge clk);
        rst = 1'b0; hv = 1'b0;
        chk("rst drain eng_buf", 32'(ebuf), 32'd0);
        chk("rst drain ack", 32'(ack), 32'd0);
        chk("rst drain host_rsp_valid", 32'(h_rv), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst drain no ack", 32'(ack), 32'd0);
            chk("rst drain buf stays", 32'(ebuf), 32'd0);
        end
        ev = 1'b1; ew = 1'b0; ea = 4'd5;
        #1 chk("rst drain eng_ready", 32'(e_ready), 32'd1);
        @(negedge clk);
        ev = 1'b0;

        // Parity: an injected write must flag on read-back only if the feature is built in.
        ev = 1'b1; ew = 1'b1; ea = 4'd9; ed = 32'h0000_000F; pinj = 1'b1;
        @(negedge clk);
        ew = 1'b0; pinj = 1'b0;
        @(negedge clk);
        ev = 1'b0;
        chk("parity inj valid", 32'(e_rv), 32'd1);
        chk("parity inj rdata", e_rd, 32'h0000_000F);
        chk("parity inj err", 32'(perr), 32'(PAR_EXP));
        hv = 1'b1; hw = 1'b1; ha = 5'h0A; hd = 32'h0000_0007;
        @(negedge clk);
        hw = 1'b0;
        @(negedge clk);
        hv = 1'b0;
        chk("parity clean valid", 32'(h_rv), 32'd1);
        chk("parity clean rdata", h_rd, 32'h0000_0007);
        chk("parity clean err", 32'(perr), 32'd0);
        @(negedge clk);
        chk("parity err one-shot", 32'(perr), 32'd0);

        // Three-bank instance: bank 2 is real, index 3 is out of range.
        h3v = 1'b1; h3w = 1'b1; h3a = 6'h21; h3d = 32'h2222_0001;
        @(negedge clk);
        h3w = 1'b0;
        @(negedge clk);
        chk("bank2 valid", 32'(h3_rv), 32'd1);
        chk("bank2 rdata", h3_rd, 32'h2222_0001);
        chk("bank2 err", 32'(h3_err), 32'd0);
        h3w = 1'b1; h3a = 6'h30; h3d = 32'hFFFF_FFFF;
        #1 chk("oor write ready", 32'(h3_ready), 32'd1);
        @(negedge clk);
        h3w = 1'b0;
        chk("oor write no rsp", 32'(h3_rv), 32'd0);
        #1 chk("oor read ready", 32'(h3_ready), 32'd1);
        @(negedge clk);
        h3v = 1'b0;
        chk("oor read valid", 32'(h3_rv), 32'd1);
        chk("oor read rdata", h3_rd, 32'd0);
        chk("oor read err", 32'(h3_err), 32'd1);
        @(negedge clk);
        chk("oor err one-shot", 32'(h3_err), 32'd0);
        chk("oor valid one-shot", 32'(h3_rv), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
